// File: rtl/wr_ingress_ctrl.sv
// Write-domain ingress of the async FIFO: 2-entry skid buffer, read-pointer synchronizer,
// fill level and almost-full flag. Define WR_SYNC3_EN for a 3-flop read-pointer synchronizer.
module wr_ingress_ctrl #(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 8,
    parameter int AFULL_MARGIN = 4
) (
    input  logic                  CLK_WRITE,
    input  logic                  WR_RST,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH:0]   rptr_R,
    output logic [ADDR_WIDTH:0]   rptr_R_SYN,
    input  logic [ADDR_WIDTH:0]   ADDR_WR,
    input  logic                  FULL_FLAG,
    output logic                  WR_EN,
    output logic [DATA_WIDTH-1:0] WR_DATA,
    output logic [ADDR_WIDTH:0]   WR_LEVEL,
    output logic                  ALMOST_FULL
);

    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [PTR_W-1:0] AFULL_THRESH = PTR_W'(DEPTH - AFULL_MARGIN);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    skid_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic                  in_ready_q, in_ready_d;

    logic [PTR_W-1:0]      sync1_q, sync1_d;
    logic [PTR_W-1:0]      sync2_q, sync2_d;
`ifdef WR_SYNC3_EN
    logic [PTR_W-1:0]      sync3_q, sync3_d;
`endif
    logic [PTR_W-1:0]      level_q, level_d;
    logic                  afull_q, afull_d;

    logic                  main_valid;
    logic                  accept;
    logic                  drain;
    logic [PTR_W-1:0]      rptr_syn;
    logic [PTR_W-1:0]      rbin;

    function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
        logic [PTR_W-1:0] b;
        b[PTR_W-1] = g[PTR_W-1];
        for (int i = PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign main_valid = (state_q != ST_EMPTY);
    assign accept     = in_valid & in_ready_q;
    // The write strobe is gated by FULL_FLAG here, so every pulse is a committed write.
    assign drain      = main_valid & ~FULL_FLAG;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d     = ST_ONE;
                    main_data_d = in_data;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    main_data_d = in_data;
                end else if (accept) begin
                    state_d     = ST_TWO;
                    skid_data_d = in_data;
                end else if (drain) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (drain) begin
                    state_d     = ST_ONE;
                    main_data_d = skid_data_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        in_ready_d = (state_d != ST_TWO);
    end

    always_ff @(posedge CLK_WRITE or negedge WR_RST) begin
        if (!WR_RST) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            skid_data_q <= '0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // All pointer bits are sampled together; Gray coding limits skew to a single bit.
    always_comb begin
        sync1_d = rptr_R;
        sync2_d = sync1_q;
`ifdef WR_SYNC3_EN
        sync3_d  = sync2_q;
        rptr_syn = sync3_q;
`else
        rptr_syn = sync2_q;
`endif
        rbin    = gray2bin(rptr_syn);
        level_d = ADDR_WR - rbin;
        afull_d = (level_d >= AFULL_THRESH);
    end

    always_ff @(posedge CLK_WRITE or negedge WR_RST) begin
        if (!WR_RST) begin
            sync1_q <= '0;
            sync2_q <= '0;
`ifdef WR_SYNC3_EN
            sync3_q <= '0;
`endif
            level_q <= '0;
            afull_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
`ifdef WR_SYNC3_EN
            sync3_q <= sync3_d;
`endif
            level_q <= level_d;
            afull_q <= afull_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign WR_EN       = drain;
    assign WR_DATA     = main_data_q;
    assign rptr_R_SYN  = rptr_syn;
    assign WR_LEVEL    = level_q;
    assign ALMOST_FULL = afull_q;

endmodule

// File: tb/tb_wr_ingress_ctrl.sv
// Scoreboard bench for wr_ingress_ctrl: accepted words are queued by the stimulus,
// a negedge monitor pops and compares every WR_EN cycle.
module tb_wr_ingress_ctrl;

    localparam int AW = 5;
    localparam int DW = 8;
`ifdef WR_SYNC3_EN
    localparam int LVL_LAT = 4;
`else
    localparam int LVL_LAT = 3;
`endif

    logic          CLK_WRITE;
    logic          WR_RST;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [AW:0]   rptr_R;
    logic [AW:0]   rptr_R_SYN;
    logic [AW:0]   ADDR_WR;
    logic          FULL_FLAG;
    logic          WR_EN;
    logic [DW-1:0] WR_DATA;
    logic [AW:0]   WR_LEVEL;
    logic          ALMOST_FULL;

    int            vectors    = 0;
    int            miscompares = 0;
    logic [DW-1:0] exp_q[$];

    wr_ingress_ctrl #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .AFULL_MARGIN(4)
    ) dut (
        .CLK_WRITE  (CLK_WRITE),
        .WR_RST     (WR_RST),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .rptr_R     (rptr_R),
        .rptr_R_SYN (rptr_R_SYN),
        .ADDR_WR    (ADDR_WR),
        .FULL_FLAG  (FULL_FLAG),
        .WR_EN      (WR_EN),
        .WR_DATA    (WR_DATA),
        .WR_LEVEL   (WR_LEVEL),
        .ALMOST_FULL(ALMOST_FULL)
    );

    initial CLK_WRITE = 1'b0;
    always #5 CLK_WRITE = ~CLK_WRITE;

    function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK_WRITE);
        #1;
    endtask

    // Offer one word and hold it until accepted, within a bounded number of cycles.
    task automatic applyStimulus(input logic [DW-1:0] data);
        bit done = 0;
        in_valid = 1'b1;
        in_data  = data;
        for (int c = 0; c < 40 && !done; c++) begin
            if (in_ready) begin
                exp_q.push_back(data);
                done = 1;
            end
            tick(1);
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL accept_timeout: data 0x%0h never accepted, expected accept", data);
        end
        in_valid = 1'b0;
        in_data  = 8'hEE;
    endtask

    task automatic waitDrained(input string name);
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) tick(1);
        checkOutput(name, exp_q.size(), 0);
    endtask

    // Monitor: one comparison per write cycle, plus the no-write-while-full rule.
    always @(negedge CLK_WRITE) begin
        if (WR_RST) begin
            if (FULL_FLAG) begin
                vectors++;
                if (WR_EN !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL wr_en_while_full: got WR_EN=%b, expected 0", WR_EN);
                end
            end
            if (WR_EN === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL unexpected_write: got WR_DATA 0x%0h, expected no write",
                             WR_DATA);
                end else begin
                    logic [DW-1:0] e;
                    e = exp_q.pop_front();
                    if (WR_DATA !== e) begin
                        miscompares++;
                        $display("[TB] FAIL wr_data: got 0x%0h, expected 0x%0h", WR_DATA, e);
                    end
                end
            end
        end
    end

    initial begin
        WR_RST    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        rptr_R    = '0;
        ADDR_WR   = '0;
        FULL_FLAG = 1'b0;

        // 1. reset and release
        tick(2);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_wr_en", WR_EN, 0);
        checkOutput("rst_level", WR_LEVEL, 0);
        checkOutput("rst_afull", ALMOST_FULL, 0);
        WR_RST = 1'b1;
        #1;
        checkOutput("rel_in_ready_before_edge", in_ready, 0);
        tick(1);
        checkOutput("rel_in_ready_after_edge", in_ready, 1);
        checkOutput("rel_wr_en", WR_EN, 0);
        checkOutput("rel_level", WR_LEVEL, 0);

        // 2. streaming
        applyStimulus(8'h01);
        checkOutput("lat_wr_en", WR_EN, 1);
        checkOutput("lat_wr_data", WR_DATA, 8'h01);
        for (int i = 2; i <= 5; i++) applyStimulus(DW'(i));
        checkOutput("stream_last_wr_en", WR_EN, 1);
        checkOutput("stream_last_data", WR_DATA, 8'h05);
        tick(1);
        checkOutput("stream_idle_wr_en", WR_EN, 0);
        waitDrained("stream_drained");

        // 3. back-pressure from FULL_FLAG
        FULL_FLAG = 1'b1;
        applyStimulus(8'hA1);
        applyStimulus(8'hA2);
        checkOutput("full_in_ready_low", in_ready, 0);
        in_valid = 1'b1;
        in_data  = 8'hA3;
        tick(3);
        checkOutput("full_in_ready_held", in_ready, 0);
        checkOutput("full_data_held", WR_DATA, 8'hA1);
        FULL_FLAG = 1'b0;
        applyStimulus(8'hA3);
        waitDrained("full_drained");

        // 4. level and almost-full threshold, then sync latency
        ADDR_WR = 6'h1C;
        rptr_R  = bin2gray(6'h00);
        tick(5);
        checkOutput("level_28", WR_LEVEL, 28);
        checkOutput("afull_28", ALMOST_FULL, 1);
        rptr_R = bin2gray(6'h01);
        tick(LVL_LAT - 2);
        checkOutput("syn_before", rptr_R_SYN, bin2gray(6'h00));
        tick(1);
        checkOutput("syn_after", rptr_R_SYN, bin2gray(6'h01));
        checkOutput("level_still_28", WR_LEVEL, 28);
        tick(1);
        checkOutput("level_27", WR_LEVEL, 27);
        checkOutput("afull_27", ALMOST_FULL, 0);
        ADDR_WR = 6'h21;
        tick(1);
        checkOutput("level_32", WR_LEVEL, 32);
        checkOutput("afull_32", ALMOST_FULL, 1);

        // 5. wrap-around
        ADDR_WR = 6'h02;
        rptr_R  = bin2gray(6'h3E);
        tick(5);
        checkOutput("wrap_level", WR_LEVEL, 4);
        checkOutput("wrap_afull", ALMOST_FULL, 0);

        // 6. reset while two entries are held
        FULL_FLAG = 1'b1;
        applyStimulus(8'hB1);
        applyStimulus(8'hB2);
        checkOutput("two_in_ready", in_ready, 0);
        FULL_FLAG = 1'b0;
        WR_RST    = 1'b0;
        #1;
        checkOutput("mid_rst_wr_en", WR_EN, 0);
        checkOutput("mid_rst_in_ready", in_ready, 0);
        checkOutput("mid_rst_level", WR_LEVEL, 0);
        exp_q.delete();
        tick(2);
        WR_RST = 1'b1;
        tick(6);
        checkOutput("post_rst_wr_en", WR_EN, 0);
        checkOutput("post_rst_level", WR_LEVEL, 4);
        applyStimulus(8'hC5);
        waitDrained("post_rst_drained");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
